// File: rtl/jh_pkg.sv
// Shared JH definitions: default round count, S0/S1 nibble tables and the E8 sequencer state enum.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package jh_pkg;

  // Number of R8 rounds in one E8 permutation for standard JH
  localparam int JH_ROUNDS = 42;

  // S-box tables, nibble i at bits [4i+3:4i]
  // S0 = 9,0,4,11,13,12,3,15,1,10,2,6,7,5,8,14
  // S1 = 3,12,6,13,5,7,1,9,15,2,0,4,11,10,14,8
  localparam logic [63:0]  JH_S0   = 64'hE857_62A1_F3CD_B409;
  localparam logic [63:0]  JH_S1   = 64'h8EAB_402F_9175_D6C3;
  localparam logic [127:0] JH_SBOX = {JH_S1, JH_S0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREF = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } jh_state_e;

  // Round-constant address clamped to the last round so the ROM index never runs past the table
  function automatic logic [5:0] jh_addr_sat(input logic [6:0] addr, input logic [5:0] last);
    return (addr > {1'b0, last}) ? last : addr[5:0];
  endfunction

endpackage

// File: rtl/jh_round_seq.sv
// E8 round sequencer: FSM, 6-bit round counter, ROM addressing and datapath enables.
// Latency: done pulses ROUNDS+2 cycles after the accepted start (one prefetch cycle, ROUNDS run cycles).
// Backpressure: none; start is accepted only in IDLE and silently dropped otherwise.
module jh_round_seq
  import jh_pkg::*;
#(
  parameter int ROUNDS = JH_ROUNDS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [5:0] rc_addr,
  output logic       load,
  output logic       update
);

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  jh_state_e  st;
  logic [5:0] rnd;

  // Enables are decoded from the registered state so the datapath acts on the same edge as the FSM
  assign load   = (st == ST_IDLE) && start;
  assign update = (st == ST_RUN);

  // Sequencer state, round counter and registered outputs; rc_addr always leads the round by one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= ST_IDLE;
      rnd     <= 6'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rc_addr <= 6'd0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (start) begin
            st      <= ST_PREF;
            rnd     <= 6'd0;
            busy    <= 1'b1;
            rc_addr <= 6'd0;
          end
        end
        ST_PREF: begin
          // Constant for round 0 lands this edge; ask for round 1 next
          st      <= ST_RUN;
          rc_addr <= jh_addr_sat(7'd1, LAST);
        end
        ST_RUN: begin
          if (rnd == LAST) begin
            st      <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            rc_addr <= 6'd0;
          end else begin
            rnd     <= rnd + 6'd1;
            rc_addr <= jh_addr_sat({1'b0, rnd} + 7'd2, LAST);
          end
        end
        ST_DONE: begin
          st   <= ST_IDLE;
          done <= 1'b0;
        end
        default: begin
          st      <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          rc_addr <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/jh_e8_ctrl.sv
// JH E8 permutation controller: holds the 1024-bit state and steps it through an external R8 round datapath.
// Latency: done pulses ROUNDS+2 cycles after the accepted start (44 for 42 rounds), no bubbles between rounds.
// Backpressure: none; start is ignored unless idle, state_out holds until the next accepted start.
module jh_e8_ctrl
  import jh_pkg::*;
#(
  parameter int ROUNDS = JH_ROUNDS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1023:0] state_in,
  output logic          busy,
  output logic          done,
  output logic [1023:0] state_out,
  output logic [5:0]    rc_addr,
  input  logic [255:0]  rc_data,
  output logic [255:0]  r8_round,
  output logic [127:0]  r8_sbox,
  output logic [1023:0] r8_state,
  output logic          r8_half,
  input  logic [1023:0] r8_result
);

  logic          load;
  logic          update;
  logic [1023:0] state_q;

  jh_round_seq #(.ROUNDS(ROUNDS)) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rc_addr (rc_addr),
    .load    (load),
    .update  (update)
  );

  // State register: captured on accepted start, replaced by the round result every run cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else if (load) begin
      state_q <= state_in;
    end else if (update) begin
      state_q <= r8_result;
    end
  end

  assign state_out = state_q;
  assign r8_state  = state_q;
  // ROM output is stale outside a round, so the datapath sees zero constants then
  assign r8_round  = update ? rc_data : '0;
  assign r8_sbox   = JH_SBOX;
  assign r8_half   = 1'b0;

endmodule

// File: tb/tb_jh_e8_ctrl.sv
module tb_jh_e8_ctrl;

  localparam int R = 42;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, start1;
  logic [1023:0] state_in, state_in1;
  logic          busy, done, busy1, done1;
  logic [1023:0] state_out, state_out1;
  logic [5:0]    rc_addr, rc_addr1;
  logic [255:0]  rc_data, rc_data1;
  logic [255:0]  r8_round, r8_round1;
  logic [127:0]  r8_sbox, r8_sbox1;
  logic [1023:0] r8_state, r8_state1;
  logic          r8_half, r8_half1;
  logic [1023:0] r8_result, r8_result1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Synthetic round-constant table (non-zero at every address)
  function automatic logic [255:0] rom_val(input int a);
    logic [255:0] v;
    logic [31:0]  w;
    for (int i = 0; i < 8; i++) begin
      w = (32'(a) + 32'd1) * 32'h9E3779B9;
      w = w ^ (32'(i) * 32'h85EBCA6B);
      v[32*i +: 32] = w + 32'h1B873593;
    end
    return v;
  endfunction

  // Stand-in round function for the external datapath
  function automatic logic [1023:0] rnd_fn(input logic [1023:0] s, input logic [255:0] c);
    logic [1023:0] t;
    t = {s[1018:0], s[1023:1019]} ^ {c, c, c, c};
    t[63:0] = t[63:0] + s[127:64];
    return t;
  endfunction

  function automatic logic [1023:0] model(input logic [1023:0] s, input int n);
    logic [1023:0] t;
    t = s;
    for (int r = 0; r < n; r++) t = rnd_fn(t, rom_val(r));
    return t;
  endfunction

  // Registered ROMs and combinational round datapaths
  always @(posedge clk) begin
    rc_data  <= rom_val(int'(rc_addr));
    rc_data1 <= rom_val(int'(rc_addr1));
  end
  assign r8_result  = rnd_fn(r8_state, r8_round);
  assign r8_result1 = rnd_fn(r8_state1, r8_round1);

  jh_e8_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
    .busy(busy), .done(done), .state_out(state_out), .rc_addr(rc_addr),
    .rc_data(rc_data), .r8_round(r8_round), .r8_sbox(r8_sbox),
    .r8_state(r8_state), .r8_half(r8_half), .r8_result(r8_result)
  );

  jh_e8_ctrl #(.ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .state_in(state_in1),
    .busy(busy1), .done(done1), .state_out(state_out1), .rc_addr(rc_addr1),
    .rc_data(rc_data1), .r8_round(r8_round1), .r8_sbox(r8_sbox1),
    .r8_state(r8_state1), .r8_half(r8_half1), .r8_result(r8_result1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed[63:0]=%h expected[63:0]=%h observed[1023:960]=%h expected[1023:960]=%h",
             tag, obs[63:0], exp[63:0], obs[1023:960], exp[1023:960]);
    end
  endtask

  // Clock through up to maxc cycles after the start cycle, recording done pulses.
  // Optionally re-pulses start at cycle inj_c, and checks the address/busy sequence.
  task automatic run_op(input int maxc, input bit chk_seq, input int inj_c,
                        input logic [1023:0] inj_d, output int done_at, output int npulse);
    done_at = -1;
    npulse  = 0;
    for (int c = 1; c <= maxc; c++) begin
      tick();
      start = (c == inj_c);
      if (c == inj_c) state_in = inj_d;
      if (done === 1'b1) begin
        npulse++;
        if (done_at < 0) done_at = c;
      end
      if (chk_seq) begin
        if (c <= R + 1)
          chk($sformatf("rc_addr_c%0d", c), 64'(rc_addr), 64'((c - 1 < R - 1) ? c - 1 : R - 1));
        chk($sformatf("busy_c%0d", c), 64'(busy), 64'((c <= R + 1) ? 1 : 0));
        if (c == 1) chk("round_zero_in_pref", r8_round[63:0], 64'd0);
        if (c == 2) chk("round0_const", r8_round[63:0], rom_val(0) >> 0);
      end
    end
  endtask

  initial begin
    int da, np;
    logic [127:0]  exp_sbox;
    logic [1023:0] pa, pb, pc, pd, pe, pp;
    int s0 [16] = '{9, 0, 4, 11, 13, 12, 3, 15, 1, 10, 2, 6, 7, 5, 8, 14};
    int s1 [16] = '{3, 12, 6, 13, 5, 7, 1, 9, 15, 2, 0, 4, 11, 10, 14, 8};

    for (int i = 0; i < 16; i++) begin
      exp_sbox[4*i +: 4]      = 4'(s0[i]);
      exp_sbox[64 + 4*i +: 4] = 4'(s1[i]);
    end
    pa = {16{64'h0123_4567_89AB_CDEF}};
    pb = {16{64'hDEAD_BEEF_0BAD_F00D}};
    pc = {32{32'hA5A5_3C3C}};
    pd = {8{128'h1111_2222_3333_4444_5555_6666_7777_8888}};
    pe = {16{64'hFEDC_BA98_7654_3210}};
    pp = {64{16'h5A0F}};

    // Reset held with start asserted
    rst_n     = 1'b0;
    start     = 1'b1;
    state_in  = '1;
    start1    = 1'b0;
    state_in1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk_w("rst_state_out", state_out, '0);
    chk("rst_rc_addr", 64'(rc_addr), 64'd0);
    chk("rst_r8_round", r8_round[63:0], 64'd0);
    chk("r8_half", 64'(r8_half), 64'd0);
    chk("r8_sbox_s0", r8_sbox[63:0], exp_sbox[63:0]);
    chk("r8_sbox_s1", r8_sbox[127:64], exp_sbox[127:64]);
    rst_n = 1'b1;
    start = 1'b0;
    tick();

    // Single run from an all-zero state
    state_in = '0;
    start    = 1'b1;
    run_op(R + 4, 1'b1, -1, '0, da, np);
    chk("run1_done_cycle", 64'(da), 64'(R + 2));
    chk("run1_done_pulses", 64'(np), 64'd1);
    chk_w("run1_state_out", state_out, model('0, R));

    // Second start mid-run is ignored; this run stops on its done cycle
    state_in = pa;
    start    = 1'b1;
    run_op(R + 2, 1'b0, 10, pb, da, np);
    chk("run2_done_cycle", 64'(da), 64'(R + 2));
    chk_w("run2_state_out", state_out, model(pa, R));

    // Start offered in the DONE cycle and held one more cycle
    start    = 1'b1;
    state_in = pc;
    tick();
    chk("b2b_done_start_ignored_busy", 64'(busy), 64'd0);
    chk("b2b_done_low", 64'(done), 64'd0);
    chk_w("b2b_state_held", state_out, model(pa, R));
    run_op(R + 4, 1'b0, -1, '0, da, np);
    chk("b2b_done_cycle", 64'(da), 64'(R + 2));
    chk("b2b_done_pulses", 64'(np), 64'd1);
    chk_w("b2b_state_out", state_out, model(pc, R));

    // Reset during round 20
    state_in = pd;
    start    = 1'b1;
    run_op(22, 1'b0, -1, '0, da, np);
    chk("midrst_no_done_before", 64'(np), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_rc_addr", 64'(rc_addr), 64'd0);
    chk_w("midrst_state_out", state_out, '0);
    chk("midrst_r8_round", r8_round[63:0], 64'd0);
    np = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done !== 1'b0) np++;
    end
    chk("midrst_done_during_reset", 64'(np), 64'd0);
    rst_n    = 1'b1;
    state_in = pe;
    start    = 1'b1;
    run_op(R + 4, 1'b0, -1, '0, da, np);
    chk("postrst_done_cycle", 64'(da), 64'(R + 2));
    chk("postrst_done_pulses", 64'(np), 64'd1);
    chk_w("postrst_state_out", state_out, model(pe, R));

    // Single-round instance
    state_in1 = pp;
    start1    = 1'b1;
    tick();
    start1 = 1'b0;
    chk("r1_c1_busy", 64'(busy1), 64'd1);
    chk("r1_c1_rc_addr", 64'(rc_addr1), 64'd0);
    chk("r1_c1_done", 64'(done1), 64'd0);
    tick();
    chk("r1_c2_rc_addr", 64'(rc_addr1), 64'd0);
    chk("r1_c2_busy", 64'(busy1), 64'd1);
    chk_w("r1_c2_state_loaded", state_out1, pp);
    tick();
    chk("r1_c3_done", 64'(done1), 64'd1);
    chk("r1_c3_busy", 64'(busy1), 64'd0);
    chk_w("r1_c3_state_out", state_out1, model(pp, 1));
    tick();
    chk("r1_c4_done", 64'(done1), 64'd0);
    chk_w("r1_c4_state_held", state_out1, model(pp, 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
